// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - per-channel LED PWM driver with saturating linear fade-in/fade-out
module led_pwm_fader #(
    parameter int CHANNELS = 4,
    parameter int PWM_BITS = 8,
    parameter int STEP     = 32
) (
    input  logic                CLK_12_MHZ,
    input  logic                reset,
    input  logic                step_tick,
    input  logic [CHANNELS-1:0] led_req,
    output logic [CHANNELS-1:0] led_out,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] MAX    = '1;
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);

    typedef enum logic [1:0] {
        S_OFF,
        S_RISING,
        S_ON,
        S_FALLING
    } state_t;

    logic [CHANNELS-1:0] r_req_q;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_level  [CHANNELS];
    logic [PWM_BITS-1:0] r_active [CHANNELS];
    state_t              r_state  [CHANNELS];
    logic [CHANNELS-1:0] r_led_out;
    logic                r_busy;

    logic [PWM_BITS:0]          w_sum        [CHANNELS];
    logic signed [PWM_BITS+1:0] w_diff       [CHANNELS];
    logic [PWM_BITS-1:0]        w_level_next [CHANNELS];
    state_t                     w_state_next [CHANNELS];
    logic [CHANNELS-1:0]        w_led_next;
    logic                       w_busy_next;

    always_comb begin
        w_led_next  = '0;
        w_busy_next = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sum[i]        = {1'b0, r_level[i]} + STEP_W;
            w_diff[i]       = $signed({2'b00, r_level[i]}) - $signed({1'b0, STEP_W});
            w_level_next[i] = r_level[i];
            w_state_next[i] = S_OFF;

            // Carry / sign bit of the widened arithmetic selects the saturation rail.
            if (step_tick) begin
                if (r_req_q[i]) begin
                    w_level_next[i] = w_sum[i][PWM_BITS] ? MAX : w_sum[i][PWM_BITS-1:0];
                end else begin
                    w_level_next[i] = w_diff[i][PWM_BITS+1] ? '0 : w_diff[i][PWM_BITS-1:0];
                end
            end

            if (r_req_q[i]) begin
                w_state_next[i] = (r_level[i] == MAX) ? S_ON : S_RISING;
            end else begin
                w_state_next[i] = (r_level[i] == '0) ? S_OFF : S_FALLING;
            end

            w_led_next[i] = (r_active[i] == MAX) || (r_pwm_cnt < r_active[i]);

            if (r_state[i] == S_RISING || r_state[i] == S_FALLING) begin
                w_busy_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_12_MHZ) begin
        if (reset) begin
            r_req_q   <= '0;
            r_pwm_cnt <= '0;
            r_led_out <= '0;
            r_busy    <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_level[i]  <= '0;
                r_active[i] <= '0;
                r_state[i]  <= S_OFF;
            end
        end else begin
            r_req_q   <= led_req;
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_led_out <= w_led_next;
            r_busy    <= w_busy_next;
            for (int i = 0; i < CHANNELS; i++) begin
                r_level[i] <= w_level_next[i];
                r_state[i] <= w_state_next[i];
                // Duty only changes at the period boundary, using the pre-step level.
                if (r_pwm_cnt == MAX) begin
                    r_active[i] <= r_level[i];
                end
            end
        end
    end

    assign led_out = r_led_out;
    assign busy    = r_busy;

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb/tb_led_pwm_fader.sv - scoreboard bench for led_pwm_fader
module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       reset;
    logic       step_tick;
    logic [3:0] led_req;
    logic [3:0] led_out;
    logic       busy;

    led_pwm_fader #(.CHANNELS(4), .PWM_BITS(8), .STEP(32)) dut (
        .CLK_12_MHZ (clk),
        .reset      (reset),
        .step_tick  (step_tick),
        .led_req    (led_req),
        .led_out    (led_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    localparam int K_LED = 0, K_BUSY = 1, K_LEVEL0 = 2, K_CNT = 3, K_HIGH0 = 4;

    typedef struct {
        int    cyc;
        int    kind;
        int    exp;
        string name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cnt_now();
        return (cyc - base) & 255;
    endfunction

    task automatic expect_at(input int dly, input int kind, input int exp, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick(input int exp_level, input string name);
        step_tick = 1'b1;
        expect_at(1, K_LEVEL0, exp_level, name);
        @(negedge clk);
        step_tick = 1'b0;
    endtask

    task automatic wait_cnt(input int c);
        do @(negedge clk); while (cnt_now() != c);
    endtask

    // Monitor: samples outputs on the falling edge and retires due expectations.
    logic [255:0] hist = '0;
    initial begin
        forever begin
            exp_t keep[$];
            int   act;
            @(negedge clk);
            hist = {hist[254:0], led_out[0]};
            keep = {};
            foreach (q[i]) begin
                if (q[i].cyc == cyc) begin
                    case (q[i].kind)
                        K_LED:    act = int'(led_out);
                        K_BUSY:   act = int'(busy);
                        K_LEVEL0: act = int'(dut.r_level[0]);
                        K_CNT:    act = int'(dut.r_pwm_cnt);
                        default:  act = $countones(hist);
                    endcase
                    n_checks++;
                    if (act != q[i].exp) begin
                        n_fail++;
                        $display("FAIL %s at cycle %0d: got %0d expected %0d", q[i].name, cyc, act, q[i].exp);
                    end
                end else if (q[i].cyc < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s: missed check cycle %0d", q[i].name, q[i].cyc);
                end else begin
                    keep.push_back(q[i]);
                end
            end
            q = keep;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset     = 1'b1;
        led_req   = 4'hF;
        step_tick = 1'b1;

        // Reset hold for three cycles with active request and strobe.
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            expect_at(k, K_LED,  0, "reset_led");
            expect_at(k, K_BUSY, 0, "reset_busy");
            expect_at(k, K_CNT,  0, "reset_cnt");
        end
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        led_req   = 4'h0;
        step_tick = 1'b0;
        base      = cyc;
        expect_at(1, K_CNT, 1, "cnt_after_release");
        @(negedge clk);

        // Ramp to 96 and measure duty.
        led_req = 4'h1;
        expect_at(2, K_BUSY, 0, "busy_before_state");
        expect_at(3, K_BUSY, 1, "busy_rising");
        @(negedge clk);
        tick(32, "up1");
        tick(64, "up2");
        tick(96, "up3");
        wait_cnt(0);
        expect_at(1,   K_LED,   1,  "duty96_first_high");
        expect_at(96,  K_LED,   1,  "duty96_last_high");
        expect_at(97,  K_LED,   0,  "duty96_first_low");
        expect_at(256, K_HIGH0, 96, "duty96_count");
        wait_cnt(0);

        // Reverse mid-ramp down to OFF.
        led_req = 4'h0;
        @(negedge clk);
        expect_at(2, K_BUSY, 1, "busy_falling");
        tick(64, "down1");
        tick(32, "down2");
        tick(0,  "down3");
        tick(0,  "down4_floor");
        expect_at(1, K_BUSY, 0, "busy_off");
        wait_cnt(0);
        expect_at(1,   K_LED,   0, "off_led");
        expect_at(256, K_HIGH0, 0, "off_count");
        wait_cnt(0);

        // Full fade-in with saturation at 255.
        led_req = 4'h1;
        @(negedge clk);
        for (int k = 1; k <= 7; k++) tick(32 * k, "fade_in");
        expect_at(2, K_BUSY, 1, "busy_last_rising");
        expect_at(3, K_BUSY, 0, "busy_on");
        tick(255, "fade_in_sat");
        wait_cnt(0);
        expect_at(256, K_HIGH0, 256, "full_on_count");
        wait_cnt(0);

        // Fall from full, saturating at 0, then rise to 64.
        led_req = 4'h0;
        @(negedge clk);
        tick(223, "fall1");
        tick(191, "fall2");
        tick(159, "fall3");
        tick(127, "fall4");
        tick(95,  "fall5");
        tick(63,  "fall6");
        tick(31,  "fall7");
        tick(0,   "fall8_floor");
        led_req = 4'h1;
        @(negedge clk);
        tick(32, "rise1");
        tick(64, "rise2");

        // Strobe coincident with the last count of a period.
        wait_cnt(255);
        step_tick = 1'b1;
        expect_at(1,   K_LEVEL0, 96, "boundary_level");
        expect_at(257, K_HIGH0,  64, "boundary_period1");
        expect_at(513, K_HIGH0,  96, "boundary_period2");
        @(negedge clk);
        step_tick = 1'b0;
        repeat (520) @(negedge clk);

        // Clean restart, all channels to 160, then reset mid-fall.
        reset = 1'b1;
        expect_at(1, K_LED,    0, "pulse_reset_led");
        expect_at(1, K_LEVEL0, 0, "pulse_reset_level");
        @(negedge clk);
        reset   = 1'b0;
        base    = cyc;
        led_req = 4'hF;
        @(negedge clk);
        for (int k = 1; k <= 5; k++) tick(32 * k, "all_up");
        led_req = 4'h0;
        @(negedge clk);
        wait_cnt(0);
        wait_cnt(5);
        expect_at(1, K_LED,  15, "falling_led_all");
        expect_at(1, K_BUSY, 1,  "falling_busy");
        @(negedge clk);
        reset = 1'b1;
        expect_at(1, K_LED,    0, "midfade_reset_led");
        expect_at(1, K_BUSY,   0, "midfade_reset_busy");
        expect_at(1, K_LEVEL0, 0, "midfade_reset_level");
        @(negedge clk);
        reset   = 1'b0;
        base    = cyc;
        led_req = 4'h1;
        @(negedge clk);
        tick(32, "restart_ramp");

        w = 0;
        while (q.size() > 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        foreach (q[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: never checked, expected %0d at cycle %0d", q[i].name, q[i].exp, q[i].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
